flash_sample_fetcher: RTL and testbench



---
 rtl/flash_sample_fetcher.sv | 156 +++++++++++++++
 tb/tb_flash_sample_fetcher.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_sample_fetcher.sv
// Flash audio sample fetcher: reads 32-bit words over an Avalon-MM read master
// and plays them out as 16-bit samples, one per divided sample tick.
module flash_sample_fetcher #(
  parameter int                    ADDR_WIDTH     = 23,
  parameter logic [ADDR_WIDTH-1:0] MAX_WORD_ADDR  = 23'h7FFFF,
  parameter int                    FREQ_DIV_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [FREQ_DIV_WIDTH-1:0] sample_freq_div,
  input  logic                      pause,
  input  logic                      forward,
  input  logic                      fetcher_reset,
  output logic                      flash_mem_read,
  output logic [ADDR_WIDTH-1:0]     flash_mem_address,
  output logic [3:0]                flash_mem_byteenable,
  input  logic                      flash_mem_waitrequest,
  input  logic [31:0]               flash_mem_readdata,
  input  logic                      flash_mem_readdatavalid,
  output logic [15:0]               audio_sample,
  output logic                      sample_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_DATA,
    S_OUT_FIRST,
    S_OUT_SECOND,
    S_ADVANCE
  } state_t;

  state_t                    r_state;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic                      r_read;
  logic [31:0]               r_word;
  logic                      r_dir;
  logic [15:0]               r_sample;
  logic                      r_valid;
  logic                      r_pending_reset;
  logic [FREQ_DIV_WIDTH-1:0] r_tick_cnt;

  logic [FREQ_DIV_WIDTH-1:0] w_div_eff;
  logic                      w_tick;
  logic                      w_restart;
  logic [ADDR_WIDTH-1:0]     w_restart_addr;

  assign w_div_eff = (sample_freq_div == '0) ? FREQ_DIV_WIDTH'(1) : sample_freq_div;
  // >= rather than == so that shrinking the divider mid-count fires at once.
  assign w_tick    = !pause && (r_tick_cnt >= (w_div_eff - FREQ_DIV_WIDTH'(1)));

  // A restart is applied immediately outside a bus transaction, otherwise it
  // waits for the outstanding read data so the Avalon read is never aborted.
  always_comb begin
    w_restart = 1'b0;
    unique case (r_state)
      S_IDLE, S_OUT_FIRST, S_OUT_SECOND, S_ADVANCE:
        w_restart = fetcher_reset;
      S_WAIT_DATA:
        w_restart = flash_mem_readdatavalid && (r_pending_reset || fetcher_reset);
      default:
        w_restart = 1'b0;
    endcase
  end

  assign w_restart_addr = forward ? '0 : MAX_WORD_ADDR;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_restart) begin
      r_tick_cnt <= '0;
    end else if (!pause) begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + FREQ_DIV_WIDTH'(1);
    end
  end

  // NOTE: every register here is updated with <= so all branches see the
  // values from before the clock edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_read          <= 1'b0;
      r_word          <= '0;
      r_dir           <= 1'b1;
      r_sample        <= '0;
      r_valid         <= 1'b0;
      r_pending_reset <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_restart) begin
        r_addr          <= w_restart_addr;
        r_read          <= 1'b1;
        r_pending_reset <= 1'b0;
        r_state         <= S_REQ;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_read  <= 1'b1;
            r_state <= S_REQ;
          end
          S_REQ: begin
            if (fetcher_reset) r_pending_reset <= 1'b1;
            if (!flash_mem_waitrequest) begin
              r_read  <= 1'b0;
              r_state <= S_WAIT_DATA;
            end
          end
          S_WAIT_DATA: begin
            if (flash_mem_readdatavalid) begin
              r_word  <= flash_mem_readdata;
              r_dir   <= forward;
              r_state <= S_OUT_FIRST;
            end else if (fetcher_reset) begin
              r_pending_reset <= 1'b1;
            end
          end
          S_OUT_FIRST: begin
            if (w_tick) begin
              r_sample <= r_dir ? r_word[15:0] : r_word[31:16];
              r_valid  <= 1'b1;
              r_state  <= S_OUT_SECOND;
            end
          end
          S_OUT_SECOND: begin
            if (w_tick) begin
              r_sample <= r_dir ? r_word[31:16] : r_word[15:0];
              r_valid  <= 1'b1;
              r_state  <= S_ADVANCE;
            end
          end
          S_ADVANCE: begin
            if (forward)
              r_addr <= (r_addr == MAX_WORD_ADDR) ? '0 : r_addr + ADDR_WIDTH'(1);
            else
              r_addr <= (r_addr == '0) ? MAX_WORD_ADDR : r_addr - ADDR_WIDTH'(1);
            r_read  <= 1'b1;
            r_state <= S_REQ;
          end
          default: begin
            r_read  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign flash_mem_read       = r_read;
  assign flash_mem_address    = r_addr;
  assign flash_mem_byteenable = 4'hF;
  assign audio_sample         = r_sample;
  assign sample_valid         = r_valid;

endmodule

// File: tb/tb_flash_sample_fetcher.sv
// Scoreboard bench for flash_sample_fetcher: a behavioural Avalon slave checks
// read addresses, a monitor checks emitted samples against queued expectations.
module tb_flash_sample_fetcher;

  localparam int             AW   = 23;
  localparam logic [AW-1:0]  MAXA = 23'h7FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   div = 32'd4;
  logic          pause = 1'b0;
  logic          forward = 1'b1;
  logic          fetcher_reset = 1'b0;
  logic          flash_mem_read;
  logic [AW-1:0] flash_mem_address;
  logic [3:0]    flash_mem_byteenable;
  logic          wr = 1'b0;
  logic [31:0]   rdata = 32'hDEAD_BEEF;
  logic          rdv = 1'b0;
  logic [15:0]   audio_sample;
  logic          sample_valid;

  flash_sample_fetcher dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .sample_freq_div         (div),
    .pause                   (pause),
    .forward                 (forward),
    .fetcher_reset           (fetcher_reset),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_waitrequest   (wr),
    .flash_mem_readdata      (rdata),
    .flash_mem_readdatavalid (rdv),
    .audio_sample            (audio_sample),
    .sample_valid            (sample_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [15:0]   exp_s_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Flash contents: word 0 is fixed, the rest derive from the address.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (a == '0) return 32'hBBBB_AAAA;
    return {a[15:0] ^ 16'h5A5A, a[15:0] ^ 16'hC3C3};
  endfunction

  task automatic push_word(input logic [AW-1:0] a, input logic dir);
    logic [31:0] w;
    w = mem_word(a);
    exp_addr_q.push_back(a);
    if (dir) begin
      exp_s_q.push_back(w[15:0]);
      exp_s_q.push_back(w[31:16]);
    end else begin
      exp_s_q.push_back(w[31:16]);
      exp_s_q.push_back(w[15:0]);
    end
  endtask

  // Avalon slave: stall_cfg waitrequest cycles per read, then data
  // lat_cfg cycles after the cycle following acceptance.
  int            stall_cfg = 0;
  int            lat_cfg = 0;
  int            stall_left = 0;
  int            pend = 0;
  int            accept_cnt = 0;
  logic          prev_stalled = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [31:0]   ret_word = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      wr = 1'b0;
      rdv = 1'b0;
      rdata = 32'hDEAD_BEEF;
      pend = 0;
      prev_stalled = 1'b0;
      stall_left = stall_cfg;
    end else begin
      if (prev_stalled)
        check("stall_hold", 32'({flash_mem_read, flash_mem_address}), 32'({1'b1, prev_addr}));
      rdv = 1'b0;
      rdata = 32'hDEAD_BEEF;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rdv = 1'b1;
          rdata = ret_word;
        end
      end
      if (flash_mem_read) begin
        if (stall_left > 0) begin
          wr = 1'b1;
          stall_left--;
        end else begin
          wr = 1'b0;
          accept_cnt++;
          if (exp_addr_q.size() != 0)
            check("rd_addr", 32'(flash_mem_address), 32'(exp_addr_q.pop_front()));
          ret_word = mem_word(flash_mem_address);
          pend = lat_cfg + 1;
          stall_left = stall_cfg;
        end
      end else begin
        wr = 1'b0;
        stall_left = stall_cfg;
      end
      prev_stalled = flash_mem_read && wr;
      prev_addr = flash_mem_address;
    end
  end

  always @(negedge clk) begin
    if (rst_n && sample_valid && exp_s_q.size() != 0)
      check("sample", 32'(audio_sample), 32'(exp_s_q.pop_front()));
  end

  task automatic do_reset();
    rst_n = 1'b0;
    pause = 1'b0;
    forward = 1'b1;
    fetcher_reset = 1'b0;
    div = 32'd4;
    stall_cfg = 0;
    lat_cfg = 0;
    repeat (2) @(negedge clk);
    accept_cnt = 0;
    exp_addr_q.delete();
    exp_s_q.delete();
  endtask

  task automatic wait_valid(output int c);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (sample_valid !== 1'b1 && k < 300);
    if (sample_valid !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL valid_timeout: no sample_valid within %0d cycles", k);
    end
    c = cyc;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_addr_q.size() != 0 || exp_s_q.size() != 0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (exp_addr_q.size() != 0 || exp_s_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: %0d reads and %0d samples still outstanding, required 0 and 0",
               name, exp_addr_q.size(), exp_s_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, t2, t3, nv, nchg, k;
    logic [15:0] held;

    // Reset values, then forward playback of word 0 at div=4.
    do_reset();
    check("rst_read", 32'(flash_mem_read), 32'd0);
    check("rst_addr", 32'(flash_mem_address), 32'd0);
    check("rst_sample", 32'(audio_sample), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("byteenable", 32'(flash_mem_byteenable), 32'hF);
    push_word(23'd0, 1'b1);
    exp_addr_q.push_back(23'd1);
    rst_n = 1'b1;
    wait_valid(t0);
    wait_valid(t1);
    check("fwd_spacing", 32'(t1 - t0), 32'd4);
    wait_drain("forward");

    // Backward start from the clip end, continuing downward.
    do_reset();
    forward = 1'b0;
    fetcher_reset = 1'b1;
    push_word(MAXA, 1'b0);
    push_word(MAXA - 23'd1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    fetcher_reset = 1'b0;
    wait_drain("backward");

    // Direction flip mid-word: current word keeps its order, next read wraps to 0.
    do_reset();
    forward = 1'b0;
    fetcher_reset = 1'b1;
    push_word(MAXA, 1'b0);
    push_word(23'd0, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    fetcher_reset = 1'b0;
    wait_valid(t0);
    forward = 1'b1;
    wait_drain("fwd_wrap");

    // Waitrequest held for 5 cycles on each read.
    do_reset();
    stall_cfg = 5;
    push_word(23'd0, 1'b1);
    rst_n = 1'b1;
    wait_valid(t0);
    wait_valid(t1);
    check("stall_accepts", 32'(accept_cnt), 32'd1);
    wait_drain("stall");

    // Pause after the first sample for 50 cycles.
    do_reset();
    push_word(23'd0, 1'b1);
    rst_n = 1'b1;
    wait_valid(t0);
    pause = 1'b1;
    held = audio_sample;
    nv = 0;
    nchg = 0;
    repeat (50) begin
      @(negedge clk);
      if (sample_valid) nv++;
      if (audio_sample !== held) nchg++;
    end
    check("pause_valid", 32'(nv), 32'd0);
    check("pause_hold", 32'(nchg), 32'd0);
    pause = 1'b0;
    t1 = cyc;
    wait_valid(t2);
    check("pause_resume", 32'(t2 - t1), 32'd4);
    wait_drain("pause");

    // fetcher_reset in WAIT_DATA, data 3 cycles later is dropped.
    do_reset();
    lat_cfg = 3;
    forward = 1'b0;
    fetcher_reset = 1'b1;
    exp_addr_q.push_back(MAXA);
    push_word(23'd0, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    fetcher_reset = 1'b0;
    k = 0;
    while (!flash_mem_read && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("in_wait_data", 32'(flash_mem_read), 32'd0);
    fetcher_reset = 1'b1;
    forward = 1'b1;
    @(negedge clk);
    fetcher_reset = 1'b0;
    wait_drain("mid_read_reset");

    // div=0: two back-to-back samples per word, one word every 5 cycles
    // (ADVANCE, REQ, WAIT_DATA, OUT_FIRST, OUT_SECOND) with a zero-wait slave.
    do_reset();
    div = 32'd0;
    push_word(23'd0, 1'b1);
    push_word(23'd1, 1'b1);
    push_word(23'd2, 1'b1);
    rst_n = 1'b1;
    wait_valid(t0);
    wait_valid(t1);
    wait_valid(t2);
    wait_valid(t3);
    check("div0_pair", 32'(t1 - t0), 32'd1);
    check("div0_period", 32'(t2 - t0), 32'd5);
    check("div0_pair2", 32'(t3 - t2), 32'd1);
    wait_drain("div0");

    // rst_n low for one cycle mid-playback.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_read", 32'(flash_mem_read), 32'd0);
    check("mid_rst_addr", 32'(flash_mem_address), 32'd0);
    check("mid_rst_sample", 32'(audio_sample), 32'd0);
    check("mid_rst_valid", 32'(sample_valid), 32'd0);
    exp_s_q.delete();
    exp_addr_q.delete();
    exp_addr_q.push_back(23'd0);
    rst_n = 1'b1;
    wait_drain("after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
